// File: rtl/lcd_line_writer.sv
// lcd_line_writer: HD44780 16x2 power-up/init, then endless two-row refresh from per-frame snapshots
module lcd_line_writer #(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_AS    = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_CMD   = 2500,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [127:0] line1_in,
  input  logic [127:0] line2_in,
  output logic [7:0]   lcd_data,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic         init_done,
  output logic         frame_done
);
  typedef enum logic [2:0] {PWRUP, INIT, ADDR1, ROW1, ADDR2, ROW2} state_t;
  typedef enum logic [1:0] {SETUP, STROBE, WAIT} phase_t;
  state_t       state, state_n;
  phase_t       phase, phase_n;
  logic [31:0]  cnt, cnt_n, phase_len;
  logic [3:0]   idx, idx_n;
  logic [127:0] snap1, snap2, row_word;
  logic [7:0]   init_byte, row_byte;
  logic         phase_end, byte_end, take_snap;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state      <= PWRUP;
      phase      <= SETUP;
      cnt        <= '0;
      idx        <= '0;
      snap1      <= '0;
      snap2      <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      if (take_snap) begin
        snap1 <= line1_in;
        snap2 <= line2_in;
      end
      if (state == INIT && state_n == ADDR1) init_done <= 1'b1;
      frame_done <= state == ROW2 && state_n == ADDR1;
    end
  // rs/data decode only from state and idx, so they hold through SETUP/STROBE/WAIT
  assign init_byte = idx == 4'd0 ? 8'h38 : idx == 4'd1 ? 8'h0C : idx == 4'd2 ? 8'h06 : 8'h01;
  assign row_word  = state == ROW2 ? snap2 : snap1;
  assign row_byte  = row_word[{~idx, 3'b111} -: 8];
  assign lcd_data  = state == PWRUP ? 8'h00 : state == INIT ? init_byte : state == ADDR1 ? 8'h80 :
                     state == ADDR2 ? 8'hC0 : row_byte;
  assign lcd_rs    = state == ROW1 || state == ROW2;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = phase == STROBE;
  always_comb begin
    phase_len = state == PWRUP ? T_PWRUP : phase == SETUP ? T_AS : phase == STROBE ? T_EN :
                (!lcd_rs && lcd_data == 8'h01) ? T_CLR : T_CMD;
    phase_end = cnt == phase_len - 32'd1;
    byte_end  = phase_end && (state == PWRUP || phase == WAIT);
    cnt_n     = phase_end ? '0 : cnt + 32'd1;
    phase_n   = (state == PWRUP || !phase_end) ? phase : phase == SETUP ? STROBE : phase == STROBE ? WAIT : SETUP;
    state_n   = !byte_end ? state :
                state == PWRUP ? INIT :
                state == INIT  ? (idx == 4'd3 ? ADDR1 : INIT) :
                state == ADDR1 ? ROW1 :
                state == ROW1  ? (idx == 4'd15 ? ADDR2 : ROW1) :
                state == ADDR2 ? ROW2 :
                (idx == 4'd15 ? ADDR1 : ROW2);
    idx_n     = !byte_end ? idx :
                (state == PWRUP || state == ADDR1 || state == ADDR2 || (state == INIT && idx == 4'd3)) ? 4'd0 :
                idx + 4'd1;
    take_snap = byte_end && state_n == ADDR1;
  end
endmodule

// File: tb/tb_lcd_line_writer.sv
// tb_lcd_line_writer: scoreboard bench; model predicts every strobe's byte/cycle and every frame_done cycle
module tb_lcd_line_writer;
  localparam int T_PWRUP = 20, T_AS = 1, T_EN = 2, T_CMD = 5, T_CLR = 10;
  localparam int BYTE = T_AS + T_EN + T_CMD;
  localparam int FRAME = 34 * BYTE;
  logic clk_in = 1'b0, rst_in = 1'b1;
  logic [127:0] line1_in, line2_in;
  logic [7:0] lcd_data;
  logic lcd_rs, lcd_rw, lcd_en, init_done, frame_done;
  typedef struct {logic rs; logic [7:0] d; int t;} exp_t;
  exp_t exp_q[$];
  exp_t got;
  int fd_q[$];
  int total = 0, bad = 0, cyc = 0, t_model = 0, init_t = 0, en_len = 0, held = 0;
  logic prev_en = 1'b0;

  lcd_line_writer #(.T_PWRUP(T_PWRUP), .T_AS(T_AS), .T_EN(T_EN), .T_CMD(T_CMD), .T_CLR(T_CLR)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .line1_in(line1_in), .line2_in(line2_in),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .init_done(init_done), .frame_done(frame_done));

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in or posedge rst_in) cyc <= rst_in ? 0 : cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] d);
    exp_t e;
    e.rs = rs;
    e.d = d;
    e.t = t_model + T_AS;
    exp_q.push_back(e);
    t_model += T_AS + T_EN + ((!rs && d == 8'h01) ? T_CLR : T_CMD);
  endtask

  task automatic push_init();
    t_model = T_PWRUP;
    push_byte(1'b0, 8'h38);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h01);
    init_t = t_model;
  endtask

  task automatic push_frame(input logic [127:0] l1, input logic [127:0] l2);
    push_byte(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) push_byte(1'b1, 8'(l1 >> (8 * (15 - i))));
    push_byte(1'b0, 8'hC0);
    for (int i = 0; i < 16; i++) push_byte(1'b1, 8'(l2 >> (8 * (15 - i))));
    fd_q.push_back(t_model);
  endtask

  function automatic logic [127:0] rand_line();
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[119:0], 8'($urandom_range(32, 126))};
    return r;
  endfunction

  function automatic int fstart(input int k);
    return init_t + k * FRAME;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_data"}, int'(lcd_data), 0);
    chk({name, "_rs"}, int'(lcd_rs), 0);
    chk({name, "_en"}, int'(lcd_en), 0);
    chk({name, "_init_done"}, int'(init_done), 0);
    chk({name, "_frame_done"}, int'(frame_done), 0);
  endtask

  always @(negedge clk_in)
    if (rst_in) prev_en = 1'b0;
    else begin
      chk("rw", int'(lcd_rw), 0);
      chk("init_done", int'(init_done), int'(cyc >= init_t));
      if (cyc < T_PWRUP) chk("pwrup_idle", int'({lcd_data, lcd_rs, lcd_en}), 0);
      if (lcd_en && !prev_en) begin
        if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
        else begin
          got = exp_q.pop_front();
          chk("byte", int'({lcd_rs, lcd_data}), int'({got.rs, got.d}));
          chk("strobe_cycle", cyc, got.t);
        end
        held = int'({lcd_rs, lcd_data});
        en_len = 1;
      end else if (lcd_en) begin
        en_len++;
        chk("hold_strobe", int'({lcd_rs, lcd_data}), held);
      end else if (prev_en) begin
        chk("en_width", en_len, T_EN);
        chk("hold_wait", int'({lcd_rs, lcd_data}), held);
      end
      if (frame_done) begin
        if (fd_q.size() == 0) chk("unexpected_frame_done", 1, 0);
        else chk("frame_done_cycle", cyc, fd_q.pop_front());
      end
      prev_en = lcd_en;
    end

  initial begin
    line1_in = "  Game  Over    ";
    line2_in = {16{8'h3E}};
    repeat (3) @(negedge clk_in);
    #1 chk_idle("reset");
    push_init();
    push_frame(line1_in, line2_in);
    @(negedge clk_in);
    #1 rst_in = 1'b0;
    // row 1 changes while column 5 strobes; the current frame keeps its snapshot
    wait_cyc(fstart(0) + 6 * BYTE + T_AS);
    chk("col5_en", int'(lcd_en), 1);
    line1_in = {16{8'h58}};
    push_frame(line1_in, line2_in);
    for (int k = 1; k < 3; k++) begin
      wait_cyc(fstart(k) + 100);
      push_frame(line1_in, line2_in);
    end
    for (int k = 3; k < 7; k++) begin
      wait_cyc(fstart(k) + $urandom_range(10, 260));
      line1_in = rand_line();
      line2_in = rand_line();
      push_frame(line1_in, line2_in);
    end
    // reset while a row-2 character is strobing
    wait_cyc(fstart(7) + (18 + $urandom_range(0, 15)) * BYTE + T_AS);
    chk("en_before_reset", int'(lcd_en), 1);
    #3 rst_in = 1'b1;
    #1 chk_idle("async_reset");
    exp_q.delete();
    fd_q.delete();
    repeat (2) @(negedge clk_in);
    line1_in = rand_line();
    line2_in = rand_line();
    push_init();
    push_frame(line1_in, line2_in);
    #1 rst_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_cyc(fstart(k) + $urandom_range(10, 260));
      line1_in = rand_line();
      line2_in = rand_line();
      push_frame(line1_in, line2_in);
    end
    wait_cyc(t_model);
    #2;
    chk("bytes_left", exp_q.size(), 0);
    chk("frame_done_left", fd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
